// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: bus initiator for the picorv32 native memory interface.
// Pre-fills a window with data(addr) = addr ^ PATTERN, then runs a
// programmable read/write stream, checks every read and gathers statistics.
module mem_traffic_gen #(
  parameter logic [31:0] ADDR_BASE    = 32'h0001_0000,
  parameter int          ADDR_SPAN    = 4096,
  parameter int          NUM_ACCESSES = 1024,
  parameter int          LOOP_WORDS   = 64,
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] PATTERN      = 32'hA5A5_5A5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] stride,
  input  logic [3:0]  wr_every,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] access_count,
  output logic [15:0] mismatch_count,
  output logic [31:0] cycle_count,
  output logic [31:0] wait_cycles,
  output logic [15:0] max_latency
);

  localparam int               OFF_W     = $clog2(ADDR_SPAN);
  localparam logic [OFF_W-1:0] OFF_MASK  = OFF_W'(ADDR_SPAN - 4);
  localparam logic [OFF_W-1:0] LOOP_MASK = OFF_W'(LOOP_WORDS * 4 - 1);
  localparam logic [OFF_W-1:0] OFF_STEP  = OFF_W'(4);
  localparam logic [15:0]      LAST_IDX  = 16'(NUM_ACCESSES - 1);
  localparam logic [31:0]      LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [15:0]       idx_q, idx_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       stride_q, stride_d;
  logic [3:0]        wr_every_q, wr_every_d;
  logic [31:0]       lat_q, lat_d;
  logic [15:0]       acc_q, acc_d, mis_q, mis_d, maxl_q, maxl_d;
  logic [31:0]       cyc_q, cyc_d, wait_q, wait_d;
  logic              error_q, error_d;

  logic              start_ok, active, xfer, tmo, last_fill, last_run, run_wr;
  logic [OFF_W-1:0]  req_off;
  logic [31:0]       req_addr, stride_bytes;
  logic [15:0]       lat16;

  // Galois LFSR, taps 32,22,2,1 (right-shifting form)
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  assign start_ok     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign active       = (state_q == S_FILL) || (state_q == S_RUN);
  assign xfer         = active && valid_q && mem_ready;
  assign tmo          = active && valid_q && !mem_ready && (lat_q >= 32'(TIMEOUT));
  assign last_fill    = (off_q == OFF_MASK);
  assign last_run     = (idx_q == LAST_IDX);
  assign run_wr       = (wr_every_q != 4'd0) && (wr_cnt_q == wr_every_q - 4'd1);
  assign req_off      = (state_q == S_RUN && mode_q == 2'd2) ? (lfsr_q[OFF_W-1:0] & OFF_MASK) : off_q;
  assign req_addr     = ADDR_BASE + 32'(req_off);
  assign stride_bytes = {14'd0, stride_q, 2'b00};
  assign lat16        = sat16(lat_q);

  // State register and all datapath/statistics flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      off_q      <= '0;
      idx_q      <= '0;
      wr_cnt_q   <= '0;
      lfsr_q     <= LFSR_SEED;
      mode_q     <= '0;
      stride_q   <= '0;
      wr_every_q <= '0;
      lat_q      <= '0;
      acc_q      <= '0;
      mis_q      <= '0;
      maxl_q     <= '0;
      cyc_q      <= '0;
      wait_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      off_q      <= off_d;
      idx_q      <= idx_d;
      wr_cnt_q   <= wr_cnt_d;
      lfsr_q     <= lfsr_d;
      mode_q     <= mode_d;
      stride_q   <= stride_d;
      wr_every_q <= wr_every_d;
      lat_q      <= lat_d;
      acc_q      <= acc_d;
      mis_q      <= mis_d;
      maxl_q     <= maxl_d;
      cyc_q      <= cyc_d;
      wait_q     <= wait_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: fill the window, run the stream, stop on completion or timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_FILL;
      S_FILL: begin
        if (tmo)                    state_d = S_DONE;
        else if (xfer && last_fill) state_d = S_RUN;
      end
      S_RUN: begin
        if (tmo)                   state_d = S_DONE;
        else if (xfer && last_run) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request sequencing, address generation, read checking and statistics
  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    off_d      = off_q;
    idx_d      = idx_q;
    wr_cnt_d   = wr_cnt_q;
    lfsr_d     = lfsr_q;
    mode_d     = mode_q;
    stride_d   = stride_q;
    wr_every_d = wr_every_q;
    lat_d      = lat_q;
    acc_d      = acc_q;
    mis_d      = mis_q;
    maxl_d     = maxl_q;
    cyc_d      = cyc_q;
    wait_d     = wait_q;
    error_d    = error_q;
    if (start_ok) begin
      mode_d     = mode;
      stride_d   = stride;
      wr_every_d = wr_every;
      error_d    = 1'b0;
      acc_d      = '0;
      mis_d      = '0;
      maxl_d     = '0;
      cyc_d      = '0;
      wait_d     = '0;
      lfsr_d     = LFSR_SEED;
      off_d      = '0;
      idx_d      = '0;
      wr_cnt_d   = '0;
      // first FILL request goes out on the very next cycle
      valid_d    = 1'b1;
      addr_d     = ADDR_BASE;
      wdata_d    = ADDR_BASE ^ PATTERN;
      wstrb_d    = 4'hF;
      lat_d      = 32'd1;
    end else if (active) begin
      // the GAP before the first RUN request is not part of the measured run
      if (state_q == S_RUN && (valid_q || idx_q != 16'd0)) cyc_d = sat_inc32(cyc_q);
      if (!valid_q) begin
        valid_d = 1'b1;
        addr_d  = req_addr;
        wdata_d = req_addr ^ PATTERN;
        wstrb_d = (state_q == S_FILL || run_wr) ? 4'hF : 4'h0;
        lat_d   = 32'd1;
      end else if (mem_ready) begin
        valid_d = 1'b0;
        if (state_q == S_FILL) begin
          off_d = last_fill ? '0 : off_q + OFF_STEP;
        end else begin
          idx_d    = idx_q + 16'd1;
          acc_d    = sat_inc16(acc_q);
          lfsr_d   = lfsr_step(lfsr_q);
          wr_cnt_d = run_wr ? 4'd0 : wr_cnt_q + 4'd1;
          unique case (mode_q)
            2'd1:    off_d = off_q + stride_bytes[OFF_W-1:0];
            2'd3:    off_d = (off_q + OFF_STEP) & LOOP_MASK;
            default: off_d = off_q + OFF_STEP;
          endcase
          wait_d = sat_add32(wait_q, lat_q);
          if (lat16 > maxl_q) maxl_d = lat16;
          if (wstrb_q == 4'h0 && mem_rdata != (addr_q ^ PATTERN)) begin
            mis_d   = sat_inc16(mis_q);
            error_d = 1'b1;
          end
        end
      end else if (tmo) begin
        valid_d = 1'b0;
        error_d = 1'b1;
      end else begin
        lat_d = lat_q + 32'd1;
      end
    end
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state_q == S_FILL) || (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign mem_valid      = valid_q;
  assign mem_instr      = 1'b0;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign error          = error_q;
  assign access_count   = acc_q;
  assign mismatch_count = mis_q;
  assign cycle_count    = cyc_q;
  assign wait_cycles    = wait_q;
  assign max_latency    = maxl_q;

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Scoreboard bench for mem_traffic_gen: expected bus transfers are queued by
// the stimulus, a monitor pops and compares each completed transfer.
module tb_mem_traffic_gen;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] PAT   = 32'hA5A5_5A5A;
  localparam int          SPAN  = 16;
  localparam int          NACC  = 16;
  localparam int          LOOPW = 2;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  mode;
  logic [15:0] stride;
  logic [3:0]  wr_every;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy, done, error;
  logic [15:0] access_count, mismatch_count, max_latency;
  logic [31:0] cycle_count, wait_cycles;

  always #5 clk = ~clk;

  mem_traffic_gen #(
    .ADDR_BASE(BASE), .ADDR_SPAN(SPAN), .NUM_ACCESSES(NACC),
    .LOOP_WORDS(LOOPW), .TIMEOUT(TMO), .PATTERN(PAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .stride(stride),
    .wr_every(wr_every), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .error(error), .access_count(access_count), .mismatch_count(mismatch_count),
    .cycle_count(cycle_count), .wait_cycles(wait_cycles), .max_latency(max_latency)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // responder configuration: lat_cfg = cycles mem_valid stays high (0 = never ready)
  int          lat_cfg  = 1;
  bit          corrupt8 = 1'b0;
  logic [31:0] mem_model [4];
  int          vcnt = 0;

  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_req(input int off, input bit wr);
    req_t r;
    r.addr  = BASE + 32'(off);
    r.wstrb = wr ? 4'hF : 4'h0;
    r.wdata = r.addr ^ PAT;
    exp_q.push_back(r);
  endtask

  task automatic push_fill();
    for (int o = 0; o < SPAN; o += 4) push_req(o, 1'b1);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] s, input logic [3:0] w);
    @(negedge clk);
    mode = m; stride = s; wr_every = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_valid", 32'(mem_valid), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic finish_checks(input string t, input int acc, input int mis, input int wt,
                               input int mx, input int cyc, input int err);
    wait_done();
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_valid"}, 32'(mem_valid), 32'd0);
    chk({t, "_error"}, 32'(error), 32'(err));
    chk({t, "_access"}, 32'(access_count), 32'(acc));
    chk({t, "_mismatch"}, 32'(mismatch_count), 32'(mis));
    chk({t, "_wait"}, wait_cycles, 32'(wt));
    chk({t, "_maxlat"}, 32'(max_latency), 32'(mx));
    chk({t, "_cycles"}, cycle_count, 32'(cyc));
    chk({t, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // responder: memory model with programmable latency and optional corruption
  initial begin
    logic [1:0] ix;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int k = 0; k < 4; k++) mem_model[k] = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid === 1'b1) begin
        vcnt++;
        if (lat_cfg != 0 && vcnt >= lat_cfg) begin
          mem_ready = 1'b1;
          ix = mem_addr[3:2];
          if (mem_wstrb == 4'hF) begin
            mem_model[ix] = mem_wdata;
          end else begin
            mem_rdata = mem_model[ix];
            if (corrupt8 && mem_addr[3:0] == 4'h8) mem_rdata[0] = ~mem_rdata[0];
          end
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        vcnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // monitor: every completed transfer is compared against the queue head
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: actual addr=%0h wstrb=%0h required none", mem_addr, mem_wstrb);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wstrb !== e.wstrb ||
              (e.wstrb == 4'hF && mem_wdata !== e.wdata)) begin
            errors++;
            $display("FAIL xfer: actual addr=%0h wstrb=%0h wdata=%0h required addr=%0h wstrb=%0h wdata=%0h",
                     mem_addr, mem_wstrb, mem_wdata, e.addr, e.wstrb, e.wdata);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] s;
    int t2_off [4] = '{0, 12, 8, 4};

    reset = 1'b1; start = 1'b1; mode = '0; stride = '0; wr_every = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_instr", 32'(mem_instr), 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    // T1: zero-wait, sequential, read only
    lat_cfg = 1; corrupt8 = 1'b0;
    push_fill();
    for (int i = 0; i < NACC; i++) push_req((i % 4) * 4, 1'b0);
    do_start(2'd0, 16'd0, 4'd0);
    finish_checks("t1", 16, 0, 16, 1, 31, 0);

    // T3: corrupt bit 0 of reads at offset 8
    corrupt8 = 1'b1;
    push_fill();
    for (int i = 0; i < NACC; i++) push_req((i % 4) * 4, 1'b0);
    do_start(2'd0, 16'd0, 4'd0);
    finish_checks("t3", 16, 4, 16, 1, 31, 1);
    corrupt8 = 1'b0;

    // T2: 3-cycle latency, stride 3, every 2nd access writes
    lat_cfg = 3;
    push_fill();
    for (int i = 0; i < NACC; i++) push_req(t2_off[i % 4], (i % 2) == 1);
    do_start(2'd1, 16'd3, 4'd2);
    finish_checks("t2", 16, 0, 48, 3, 63, 0);

    // T4: responder never ready -> timeout on the first FILL request
    lat_cfg = 0;
    do_start(2'd0, 16'd0, 4'd0);
    n = 0;
    while (mem_valid === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_valid_high_cycles", 32'(n), 32'(TMO));
    wait_done();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_access", 32'(access_count), 32'd0);
    chk("t4_valid", 32'(mem_valid), 32'd0);

    // T5: loop mode over 2 words, every 3rd access writes, 2-cycle latency
    lat_cfg = 2;
    push_fill();
    for (int i = 0; i < NACC; i++) push_req((i % 2) * 4, (i % 3) == 2);
    do_start(2'd3, 16'd0, 4'd3);
    finish_checks("t5", 16, 0, 32, 2, 47, 0);

    // T6: LFSR addressing against the cache model, every 4th access writes
    lat_cfg = 1;
    push_fill();
    s = 32'hACE1_0001;
    for (int i = 0; i < NACC; i++) begin
      push_req(int'(s & 32'h0000_000C), (i % 4) == 3);
      s = lfsr_nx(s);
    end
    do_start(2'd2, 16'd0, 4'd4);
    finish_checks("t6", 16, 0, 16, 1, 31, 0);

    // T7: reset in the middle of a RUN request
    lat_cfg = 3; corrupt8 = 1'b1;
    push_fill();
    for (int i = 0; i < NACC; i++) push_req((i % 4) * 4, 1'b0);
    do_start(2'd0, 16'd0, 4'd0);
    n = 0;
    while (!(access_count >= 16'd4 && mem_valid === 1'b1) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t7_run_reached", 32'(n < 2000), 32'd1);
    chk("t7_pre_mismatch", 32'(mismatch_count), 32'd1);
    chk("t7_pre_error", 32'(error), 32'd1);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("t7_valid", 32'(mem_valid), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_error", 32'(error), 32'd0);
    chk("t7_access", 32'(access_count), 32'd0);
    chk("t7_mismatch", 32'(mismatch_count), 32'd0);
    chk("t7_wait", wait_cycles, 32'd0);
    chk("t7_maxlat", 32'(max_latency), 32'd0);
    chk("t7_cycles", cycle_count, 32'd0);
    chk("t7_addr", mem_addr, 32'd0);
    chk("t7_wdata", mem_wdata, 32'd0);
    chk("t7_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("t7_post_valid", 32'(mem_valid), 32'd0);
    chk("t7_post_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_traffic_gen.md
# mem_traffic_gen

Self-checking bus initiator that drives the picorv32 native memory interface (mem_valid/mem_ready handshake) in place of the CPU core. It lets the team characterise the cache and main-memory path in isolation. After a start pulse it pre-fills an address window with a known pattern, then issues a programmable stream of reads and writes (sequential, strided, pseudo-random or looped). It checks every read against the pattern and reports access count, total cycles, wait cycles, worst-case latency and mismatches.

## Interface
- ADDR_BASE, 32'h0001_0000, byte base address of the test window (word aligned)
- ADDR_SPAN, 4096, window size in bytes; power of two, ≥ 8
- NUM_ACCESSES, 1024, accesses in the run phase (1..65535)
- LOOP_WORDS, 64, word count of the repeating loop in mode 3 (power of two, ≤ ADDR_SPAN/4)
- TIMEOUT, 1024, max cycles mem_valid may stay high without mem_ready
- PATTERN, 32'hA5A5_5A5A, XOR key for data: data(addr) = addr ^ PATTERN

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a test when idle, ignored while busy
- mode  in  2  0 sequential, 1 strided, 2 LFSR random, 3 loop; sampled on start
- stride  in  16  word stride for mode 1; sampled on start
- wr_every  in  4  every Nth run access is a write; 0 = read only; sampled on start
- mem_valid  out  1  request valid
- mem_instr  out  1  tied 0
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF on write, 4'h0 on read
- mem_ready  in  1  responder completes transfer
- mem_rdata  in  32  read data, valid when mem_ready=1 on a read
- busy  out  1  test in progress
- done  out  1  high from test end until next accepted start or reset
- error  out  1  set on timeout or any mismatch; cleared on start
- access_count  out  16  completed run-phase accesses
- mismatch_count  out  16  run-phase reads with mem_rdata ≠ data(addr), saturating
- cycle_count  out  32  cycles from run-phase first request to done, saturating
- wait_cycles  out  32  sum of run-phase per-access latencies, saturating
- max_latency  out  16  worst run-phase latency, saturating

## Operation
- States: IDLE, FILL, RUN, DONE. Each transfer has a REQ sub-step (mem_valid high) and a GAP sub-step (mem_valid low for exactly one cycle).
- IDLE: start=1 → latch mode/stride/wr_every; clear error and all counters; clear done; LFSR ← 32'hACE1_0001; go to FILL at offset 0.
- FILL: write data(addr) to every word of the window, offset 0, 4, …, ADDR_SPAN-4. After the last write completes, go to RUN with access index i=0. FILL transfers are not counted.
- RUN: for i = 0..NUM_ACCESSES-1, addr = ADDR_BASE + offset_i.
  - mode 0: offset_0 = 0; offset_{i+1} = (offset_i + 4) mod ADDR_SPAN.
  - mode 1: offset_{i+1} = (offset_i + 4·stride) mod ADDR_SPAN. stride=0 stays on offset 0.
  - mode 2: offset_i = LFSR & (ADDR_SPAN-4). The Galois LFSR (taps 32,22,2,1) advances once per completed run access.
  - mode 3: offset_i = (i mod LOOP_WORDS)·4.
- Write decision: access i is a write iff wr_every≠0 and (i mod wr_every) = wr_every-1. Use a modulo counter, not a divider. Write data = data(addr); a read therefore always expects data(addr).
- Read check: on the mem_ready cycle of a run read, if mem_rdata ≠ data(addr), increment mismatch_count and set error.
- Timeout: if mem_valid has been high for TIMEOUT cycles without mem_ready, drop mem_valid, set error, go to DONE. Applies in FILL and RUN.
- DONE: busy=0, done=1. start → behaves as in IDLE.
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0, all counters 0, state IDLE, LFSR=32'hACE1_0001.
- Reset mid-transfer: mem_valid is low on the cycle after reset is sampled; no further requests until a new start.

## Timing
- start sampled at edge k → mem_valid=1 with the first FILL request at edge k+1 (busy=1 from k+1).
- Handshake: mem_addr, mem_wdata and mem_wstrb are stable while mem_valid=1. A transfer completes on the edge where mem_valid=1 and mem_ready=1. mem_valid is 0 the next cycle (GAP), and the next request is asserted the cycle after that. Minimum 2 cycles per transfer.
- mem_ready while mem_valid=0 is ignored.
- Latency per access = cycles mem_valid is high, including the ready cycle (minimum 1). wait_cycles adds this value; max_latency takes the max.
- cycle_count counts from the first RUN request cycle through the cycle before done rises.
- done and busy change on the same edge: the edge after the last RUN transfer completes, or after a timeout.
- access_count increments on each RUN completion edge; the final value equals NUM_ACCESSES on a normal finish.

## Test plan
- Zero-wait responder (mem_ready=1 whenever mem_valid), mode 0, wr_every=0, NUM_ACCESSES=8, ADDR_SPAN=16 → reads at offsets 0,4,8,12,0,…; mismatch_count=0; max_latency=1; wait_cycles=8; access_count=8.
- Responder with 3-cycle latency, mode 1, stride=3, wr_every=2 → even-index accesses read, odd-index write with mem_wstrb=4'hF; max_latency=3; wait_cycles=3·NUM_ACCESSES.
- Responder that corrupts bit 0 of rdata at offset 8 → mismatch_count equals the number of reads at offset 8; error=1; done=1.
- Responder that never asserts mem_ready, TIMEOUT=16 → mem_valid high 16 cycles then 0; error=1; done=1; busy=0; access_count=0.
- Mode 2 against a cache model → addresses match a software LFSR reference starting from seed 32'hACE1_0001; mismatch_count=0.
- reset asserted for one cycle while mem_valid=1 in RUN → next cycle mem_valid=0 with all outputs at reset values; start in IDLE ignored while reset is high.
